combat_arbiter: RTL and testbench

//  Sequences all damage events of a round between two players. It arbitrates attack requests, times each attack (windup,

---
 rtl/combat_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_combat_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/combat_arbiter.sv
// combat_arbiter: sequences the damage events of one round between two players.
// Arbitrates attack requests, times each attack (windup, strike, recovery), turns a
// strike into a one-cycle hit/block pulse for the defender, runs the round timer and
// declares the winner.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   frame_tick_i                  one-cycle pulse per video frame (round timer)
//   start_i                       begins a round from IDLE or OVER
//   p1/p2_attack_i, p1/p2_guard_i player buttons (levels)
//   in_range_i                    players close enough to connect
//   p1/p2_health_i, p1/p2_death_i health_bar status
//   p1/p2_hit_o, p1/p2_block_o    one-cycle pulses to the health bars
//   attacker_o                    00 none, 01 P1, 10 P2
//   busy_o, round_active_o, round_over_o  state decode
//   winner_o                      00 none, 01 P1, 10 P2, 11 draw
//   time_left_o                   frame ticks remaining in the round
module combat_arbiter #(
    parameter int unsigned WINDUP_CYC   = 8,
    parameter int unsigned COOLDOWN_CYC = 16,
    parameter int unsigned ROUND_TICKS  = 5400,
    parameter int unsigned TIME_W       = 13
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              frame_tick_i,
    input  logic              start_i,
    input  logic              p1_attack_i,
    input  logic              p2_attack_i,
    input  logic              p1_guard_i,
    input  logic              p2_guard_i,
    input  logic              in_range_i,
    input  logic [7:0]        p1_health_i,
    input  logic [7:0]        p2_health_i,
    input  logic              p1_death_i,
    input  logic              p2_death_i,
    output logic              p1_hit_o,
    output logic              p1_block_o,
    output logic              p2_hit_o,
    output logic              p2_block_o,
    output logic [1:0]        attacker_o,
    output logic              busy_o,
    output logic              round_active_o,
    output logic              round_over_o,
    output logic [1:0]        winner_o,
    output logic [TIME_W-1:0] time_left_o
);

    localparam int unsigned CNT_MAX = (WINDUP_CYC > COOLDOWN_CYC) ? WINDUP_CYC : COOLDOWN_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIGHT,
        S_WINDUP,
        S_STRIKE,
        S_RECOVER,
        S_OVER
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         attacker_q, attacker_d;
    logic [1:0]         winner_q, winner_d;
    logic [TIME_W-1:0]  time_left_q, time_left_d;
    logic               prio_q, prio_d;          // 0: P1 wins a tie, 1: P2
    logic               p1_prev_q, p2_prev_q;
    logic               p1_hit_q, p1_hit_d, p1_block_q, p1_block_d;
    logic               p2_hit_q, p2_hit_d, p2_block_q, p2_block_d;
    logic               busy_q, busy_d;
    logic               active_q, active_d;
    logic               over_q, over_d;
    logic               p1_req, p2_req, in_round;

    // State register and all registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            attacker_q  <= '0;
            winner_q    <= '0;
            time_left_q <= '0;
            prio_q      <= 1'b0;
            p1_prev_q   <= 1'b0;
            p2_prev_q   <= 1'b0;
            p1_hit_q    <= 1'b0;
            p1_block_q  <= 1'b0;
            p2_hit_q    <= 1'b0;
            p2_block_q  <= 1'b0;
            busy_q      <= 1'b0;
            active_q    <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            attacker_q  <= attacker_d;
            winner_q    <= winner_d;
            time_left_q <= time_left_d;
            prio_q      <= prio_d;
            p1_prev_q   <= p1_attack_i;
            p2_prev_q   <= p2_attack_i;
            p1_hit_q    <= p1_hit_d;
            p1_block_q  <= p1_block_d;
            p2_hit_q    <= p2_hit_d;
            p2_block_q  <= p2_block_d;
            busy_q      <= busy_d;
            active_q    <= active_d;
            over_q      <= over_d;
        end
    end

    // Next-state, timer, arbitration and strike resolution
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        attacker_d  = attacker_q;
        winner_d    = winner_q;
        time_left_d = time_left_q;
        prio_d      = prio_q;
        p1_hit_d    = 1'b0;
        p1_block_d  = 1'b0;
        p2_hit_d    = 1'b0;
        p2_block_d  = 1'b0;

        p1_req   = p1_attack_i & ~p1_prev_q;
        p2_req   = p2_attack_i & ~p2_prev_q;
        in_round = (state_q == S_FIGHT) || (state_q == S_WINDUP) ||
                   (state_q == S_STRIKE) || (state_q == S_RECOVER);

        if (in_round && frame_tick_i && (time_left_q != '0)) begin
            time_left_d = time_left_q - TIME_W'(1);
        end

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_i) begin
                    time_left_d = TIME_W'(ROUND_TICKS);
                    winner_d    = 2'b00;
                    prio_d      = 1'b0;
                    state_d     = S_FIGHT;
                end
            end
            S_FIGHT: begin
                if (p1_req || p2_req) begin
                    // Simultaneous requests go to the priority holder, which then yields
                    if (p1_req && p2_req) begin
                        attacker_d = prio_q ? 2'b10 : 2'b01;
                        prio_d     = ~prio_q;
                    end else begin
                        attacker_d = p1_req ? 2'b01 : 2'b10;
                    end
                    cnt_d   = CNT_W'(WINDUP_CYC - 1);
                    state_d = S_WINDUP;
                end
            end
            S_WINDUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STRIKE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STRIKE: begin
                if (in_range_i) begin
                    if (attacker_q == 2'b01) begin
                        p2_block_d = p2_guard_i;
                        p2_hit_d   = ~p2_guard_i;
                    end else begin
                        p1_block_d = p1_guard_i;
                        p1_hit_d   = ~p1_guard_i;
                    end
                end
                cnt_d   = CNT_W'(COOLDOWN_CYC - 1);
                state_d = S_RECOVER;
            end
            S_RECOVER: begin
                if (cnt_q == '0) begin
                    attacker_d = 2'b00;
                    state_d    = S_FIGHT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Round end overrides everything else in the cycle, death before timer expiry
        if (in_round && (p1_death_i || p2_death_i || (time_left_q == '0))) begin
            if (p1_death_i && p2_death_i) begin
                winner_d = 2'b11;
            end else if (p1_death_i) begin
                winner_d = 2'b10;
            end else if (p2_death_i) begin
                winner_d = 2'b01;
            end else if (p1_health_i > p2_health_i) begin
                winner_d = 2'b01;
            end else if (p1_health_i < p2_health_i) begin
                winner_d = 2'b10;
            end else begin
                winner_d = 2'b11;
            end
            p1_hit_d   = 1'b0;
            p1_block_d = 1'b0;
            p2_hit_d   = 1'b0;
            p2_block_d = 1'b0;
            attacker_d = 2'b00;
            cnt_d      = '0;
            state_d    = S_OVER;
        end

        busy_d   = (state_d == S_WINDUP) || (state_d == S_STRIKE) || (state_d == S_RECOVER);
        active_d = busy_d || (state_d == S_FIGHT);
        over_d   = (state_d == S_OVER);
    end

    assign p1_hit_o       = p1_hit_q;
    assign p1_block_o     = p1_block_q;
    assign p2_hit_o       = p2_hit_q;
    assign p2_block_o     = p2_block_q;
    assign attacker_o     = attacker_q;
    assign busy_o         = busy_q;
    assign round_active_o = active_q;
    assign round_over_o   = over_q;
    assign winner_o       = winner_q;
    assign time_left_o    = time_left_q;

endmodule

// File: tb/tb_combat_arbiter.sv
// Directed bench for combat_arbiter (WINDUP=8, COOLDOWN=16, ROUND_TICKS=4).
module tb_combat_arbiter;

    localparam int unsigned W  = 8;
    localparam int unsigned C  = 16;
    localparam int unsigned RT = 4;
    localparam int unsigned TW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_tick, start, p1_attack, p2_attack, p1_guard, p2_guard, in_range;
    logic [7:0]    p1_health, p2_health;
    logic          p1_death, p2_death;
    logic          p1_hit, p1_block, p2_hit, p2_block;
    logic [1:0]    attacker, winner;
    logic          busy, round_active, round_over;
    logic [TW-1:0] time_left;

    logic [3:0]     pulses;
    logic [TW+10:0] all_out;

    int checks = 0;
    int errors = 0;

    assign pulses  = {p1_hit, p1_block, p2_hit, p2_block};
    assign all_out = {pulses, attacker, busy, round_active, round_over, winner, time_left};

    always #5 clk = ~clk;

    combat_arbiter #(
        .WINDUP_CYC  (W),
        .COOLDOWN_CYC(C),
        .ROUND_TICKS (RT),
        .TIME_W      (TW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .frame_tick_i  (frame_tick),
        .start_i       (start),
        .p1_attack_i   (p1_attack),
        .p2_attack_i   (p2_attack),
        .p1_guard_i    (p1_guard),
        .p2_guard_i    (p2_guard),
        .in_range_i    (in_range),
        .p1_health_i   (p1_health),
        .p2_health_i   (p2_health),
        .p1_death_i    (p1_death),
        .p2_death_i    (p2_death),
        .p1_hit_o      (p1_hit),
        .p1_block_o    (p1_block),
        .p2_hit_o      (p2_hit),
        .p2_block_o    (p2_block),
        .attacker_o    (attacker),
        .busy_o        (busy),
        .round_active_o(round_active),
        .round_over_o  (round_over),
        .winner_o      (winner),
        .time_left_o   (time_left)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0;
        p1_attack = 1'b0; p2_attack = 1'b0; p1_guard = 1'b0; p2_guard = 1'b0;
        in_range = 1'b0; p1_health = 8'd100; p2_health = 8'd100;
        p1_death = 1'b0; p2_death = 1'b0;
        #3;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        p1_attack = 1'b1;
        tick(); tick();
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL idle_ignores_attack: got %h expected 0", all_out);
        end
        p1_attack = 1'b0;
    endtask

    task automatic test_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({round_active, busy, round_over, winner, time_left} !== {1'b1, 1'b0, 1'b0, 2'b00, TW'(RT)}) begin
            errors++;
            $display("FAIL start_fight: got act=%b busy=%b over=%b win=%b tl=%0d expected 1 0 0 00 %0d",
                     round_active, busy, round_over, winner, time_left, RT);
        end
    endtask

    task automatic test_hit();
        logic [3:0] exp_p;
        p1_attack = 1'b0; in_range = 1'b1; p2_guard = 1'b0;
        tick();
        p1_attack = 1'b1;
        for (int i = 1; i <= 27; i++) begin
            tick();
            exp_p = (i == 10) ? 4'b0010 : 4'b0000;
            checks++;
            if (pulses !== exp_p) begin
                errors++; $display("FAIL hit_pulse c%0d: got %b expected %b", i, pulses, exp_p);
            end
            checks++;
            if (busy !== 1'(i <= 25) || attacker !== ((i <= 25) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL hit_busy c%0d: got busy=%b att=%b expected %b %b",
                         i, busy, attacker, 1'(i <= 25), (i <= 25) ? 2'b01 : 2'b00);
            end
        end
        p1_attack = 1'b0;
    endtask

    task automatic test_block_miss();
        logic [3:0] exp_p;
        for (int k = 0; k < 2; k++) begin
            p1_attack = 1'b0; p2_guard = 1'b1; in_range = (k == 0);
            tick();
            p1_attack = 1'b1;
            for (int i = 1; i <= 26; i++) begin
                tick();
                exp_p = (k == 0 && i == 10) ? 4'b0001 : 4'b0000;
                checks++;
                if (pulses !== exp_p) begin
                    errors++; $display("FAIL block_miss_pulse k%0d c%0d: got %b expected %b", k, i, pulses, exp_p);
                end
                checks++;
                if (busy !== 1'(i <= 25) || round_active !== 1'b1) begin
                    errors++;
                    $display("FAIL block_miss_state k%0d c%0d: got busy=%b act=%b expected %b 1",
                             k, i, busy, round_active, 1'(i <= 25));
                end
            end
        end
        p1_attack = 1'b0; p2_guard = 1'b0; in_range = 1'b1;
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_p;
        logic [1:0] exp_a;
        for (int k = 0; k < 2; k++) begin
            p1_attack = 1'b0; p2_attack = 1'b0; in_range = 1'b1;
            p1_guard = (k == 1); p2_guard = 1'b0;
            tick();
            p1_attack = 1'b1; p2_attack = 1'b1;
            for (int i = 1; i <= 27; i++) begin
                tick();
                // first pass: a second P2 edge lands in WINDUP and must be dropped
                if (k == 0 && i == 1) p2_attack = 1'b0;
                if (k == 0 && i == 2) p2_attack = 1'b1;
                exp_a = (i <= 25) ? ((k == 0) ? 2'b01 : 2'b10) : 2'b00;
                exp_p = (i == 10) ? ((k == 0) ? 4'b0010 : 4'b0100) : 4'b0000;
                checks++;
                if (attacker !== exp_a || pulses !== exp_p) begin
                    errors++;
                    $display("FAIL simul k%0d c%0d: got att=%b pulses=%b expected %b %b",
                             k, i, attacker, pulses, exp_a, exp_p);
                end
                checks++;
                if (busy !== 1'(i <= 25)) begin
                    errors++; $display("FAIL simul_busy k%0d c%0d: got %b expected %b", k, i, busy, 1'(i <= 25));
                end
            end
        end
        p1_attack = 1'b0; p2_attack = 1'b0; p1_guard = 1'b0;
    endtask

    task automatic test_death_windup();
        p1_attack = 1'b0; p2_attack = 1'b0;
        tick();
        p1_attack = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b1 || attacker !== 2'b01) begin
            errors++; $display("FAIL death_pre: got busy=%b att=%b expected 1 01", busy, attacker);
        end
        p2_death = 1'b1;
        tick();
        p2_death = 1'b0;
        checks++;
        if ({round_over, winner, attacker, busy, round_active} !== {1'b1, 2'b01, 2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL death_over: got over=%b win=%b att=%b busy=%b act=%b expected 1 01 00 0 0",
                     round_over, winner, attacker, busy, round_active);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (pulses !== 4'b0000 || round_over !== 1'b1 || winner !== 2'b01) begin
                errors++;
                $display("FAIL death_hold c%0d: got pulses=%b over=%b win=%b expected 0000 1 01",
                         i, pulses, round_over, winner);
            end
        end
        p1_attack = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({round_active, round_over, winner, time_left} !== {1'b1, 1'b0, 2'b00, TW'(RT)}) begin
            errors++;
            $display("FAIL death_restart: got act=%b over=%b win=%b tl=%0d expected 1 0 00 %0d",
                     round_active, round_over, winner, time_left, RT);
        end
    endtask

    task automatic test_timer();
        logic [1:0] exp_w;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            p1_health = (k == 0) ? 8'd100 : 8'd120;
            p2_health = (k == 0) ? 8'd100 : 8'd80;
            for (int j = 1; j <= 4; j++) begin
                frame_tick = 1'b1;
                tick();
                checks++;
                if (time_left !== TW'(RT - j) || round_over !== 1'b0) begin
                    errors++;
                    $display("FAIL timer_count k%0d t%0d: got tl=%0d over=%b expected %0d 0",
                             k, j, time_left, round_over, RT - j);
                end
            end
            frame_tick = 1'b0;
            if (k == 2) p1_death = 1'b1;
            tick();
            p1_death = 1'b0;
            exp_w = (k == 0) ? 2'b11 : ((k == 1) ? 2'b01 : 2'b10);
            checks++;
            if (round_over !== 1'b1 || winner !== exp_w || round_active !== 1'b0) begin
                errors++;
                $display("FAIL timer_winner k%0d: got over=%b win=%b act=%b expected 1 %b 0",
                         k, round_over, winner, round_active, exp_w);
            end
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        tick();
        start = 1'b0;
        p1_attack = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b1 || attacker !== 2'b01) begin
            errors++; $display("FAIL rst_mid_pre: got busy=%b att=%b expected 1 01", busy, attacker);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL rst_mid_async: got %h expected 0", all_out);
        end
        tick();
        rst_n = 1'b1;
        p1_attack = 1'b0;
        tick();
        p1_attack = 1'b1;
        tick(); tick();
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL rst_mid_idle: got %h expected 0", all_out);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (round_active !== 1'b1 || time_left !== TW'(RT) || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_start: got act=%b tl=%0d busy=%b expected 1 %0d 0",
                     round_active, time_left, busy, RT);
        end
        p1_attack = 1'b0;
        tick();
        p1_attack = 1'b1;
        tick();
        checks++;
        if (attacker !== 2'b01 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_attack: got att=%b busy=%b expected 01 1", attacker, busy);
        end
        p1_attack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_block_miss();
        test_simultaneous();
        test_death_windup();
        test_timer();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
